// File: rtl/bp_io_cmd_arbiter_pkg.sv
// bp_io_cmd_arbiter_pkg: error bit positions shared by the I/O command arbiter and its users.
package bp_io_cmd_arbiter_pkg;
  typedef enum logic [0:0] {
    e_io_arb_err_unexp   = 1'b0,
    e_io_arb_err_timeout = 1'b1
  } bp_io_arb_err_e;
  localparam int io_arb_err_width_gp = 2;
endpackage

// File: rtl/bp_io_cmd_arbiter_if.sv
// bp_io_cmd_arbiter_if: requester-side and processor-side command/response channels of the I/O arbiter.
interface bp_io_cmd_arbiter_if #(parameter int num_req_p = 2, msg_width_p = 64);
  logic [num_req_p-1:0][msg_width_p-1:0] req_cmd_i;
  logic [num_req_p-1:0] req_cmd_v_i;
  logic [num_req_p-1:0] req_cmd_yumi_o;
  logic [msg_width_p-1:0] req_resp_o;
  logic [num_req_p-1:0] req_resp_v_o;
  logic [num_req_p-1:0] req_resp_ready_i;
  logic [msg_width_p-1:0] cmd_o;
  logic cmd_v_o;
  logic cmd_yumi_i;
  logic [msg_width_p-1:0] resp_i;
  logic resp_v_i;
  logic resp_ready_o;
  modport slave (
    input req_cmd_i, req_cmd_v_i, req_resp_ready_i, cmd_yumi_i, resp_i, resp_v_i,
    output req_cmd_yumi_o, req_resp_o, req_resp_v_o, cmd_o, cmd_v_o, resp_ready_o
  );
  modport master (
    output req_cmd_i, req_cmd_v_i, req_resp_ready_i, cmd_yumi_i, resp_i, resp_v_i,
    input req_cmd_yumi_o, req_resp_o, req_resp_v_o, cmd_o, cmd_v_o, resp_ready_o
  );
endinterface

// File: rtl/bp_io_cmd_arbiter_fifo.sv
// bsg_fifo_1r1w_small: small ready-then-valid circular FIFO holding requester tags in issue order.
module bsg_fifo_1r1w_small #(parameter int width_p = 1, els_p = 4) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  logic [width_p-1:0] mem_r [els_p];
  logic [ptr_w_lp-1:0] rptr_r, wptr_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic enq, deq;
  assign ready_o = cnt_r != cnt_w_lp'(els_p);
  assign v_o = cnt_r != '0;
  assign data_o = mem_r[rptr_r];
  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
      cnt_r <= '0;
    end else begin
      if (enq) wptr_r <= (wptr_r == ptr_w_lp'(els_p - 1)) ? '0 : wptr_r + ptr_w_lp'(1);
      if (deq) rptr_r <= (rptr_r == ptr_w_lp'(els_p - 1)) ? '0 : rptr_r + ptr_w_lp'(1);
      cnt_r <= cnt_r + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    end
  always_ff @(posedge clk_i)
    if (enq) mem_r[wptr_r] <= data_i;
endmodule

// File: rtl/bp_io_cmd_arbiter.sv
// bp_io_cmd_arbiter: round-robin sharing of the inbound I/O command channel with in-order response routing.
// Define BP_IO_CMD_ARB_TIMEOUT_EN to enable the response-timeout error (err_o[1]).
module bp_io_cmd_arbiter
  import bp_io_cmd_arbiter_pkg::*;
#(parameter int num_req_p = 2, msg_width_p = 64, max_outstanding_p = 4, timeout_p = 4096) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  bp_io_cmd_arbiter_if.slave       io,
  output logic [io_arb_err_width_gp-1:0] err_o
);
  localparam int id_w_lp = $clog2(num_req_p);
  logic [id_w_lp-1:0] ptr_r, win, cand, head;
  logic found, tagq_ready, tagq_v, acc, deq, tmo;
  logic [io_arb_err_width_gp-1:0] err_r;
  // scan from furthest to nearest so the closest valid requester at/after the pointer wins
  always_comb begin
    win = ptr_r;
    cand = ptr_r;
    found = 1'b0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      cand = id_w_lp'((int'(ptr_r) + k) % num_req_p);
      if (io.req_cmd_v_i[cand]) begin
        win = cand;
        found = 1'b1;
      end
    end
  end
  assign io.cmd_v_o = found & tagq_ready;
  assign io.cmd_o = io.req_cmd_i[win];
  assign acc = io.cmd_v_o & io.cmd_yumi_i;
  assign io.req_cmd_yumi_o = acc ? num_req_p'(1) << win : '0;
  assign io.req_resp_o = io.resp_i;
  assign io.req_resp_v_o = (io.resp_v_i & tagq_v) ? num_req_p'(1) << head : '0;
  assign io.resp_ready_o = tagq_v & io.req_resp_ready_i[head];
  assign deq = io.resp_v_i & io.resp_ready_o;
  bsg_fifo_1r1w_small #(.width_p(id_w_lp), .els_p(max_outstanding_p)) tagq (
    .clk_i,
    .reset_n_i,
    .v_i(acc),
    .ready_o(tagq_ready),
    .data_i(win),
    .v_o(tagq_v),
    .data_o(head),
    .yumi_i(deq)
  );
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) ptr_r <= '0;
    else if (acc) ptr_r <= (win == id_w_lp'(num_req_p - 1)) ? '0 : win + id_w_lp'(1);
`ifdef BP_IO_CMD_ARB_TIMEOUT_EN
  localparam int tmo_w_lp = $clog2(timeout_p + 1);
  logic [tmo_w_lp-1:0] idle_r;
  assign tmo = idle_r == tmo_w_lp'(timeout_p);
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) idle_r <= '0;
    else idle_r <= (deq | ~tagq_v) ? '0 : tmo ? idle_r : idle_r + tmo_w_lp'(1);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_p;
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) err_r <= '0;
    else begin
      if (io.resp_v_i & ~tagq_v) err_r[e_io_arb_err_unexp] <= 1'b1;
      if (tmo) err_r[e_io_arb_err_timeout] <= 1'b1;
    end
  assign err_o = err_r;
endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// tb_bp_io_cmd_arbiter: directed and randomized checks of bp_io_cmd_arbiter against a queue-based reference model.
module tb_bp_io_cmd_arbiter;
  localparam int N = 2, W = 16, MO = 4, TO = 16;
`ifdef BP_IO_CMD_ARB_TIMEOUT_EN
  localparam logic TMO_EXP = 1'b1;
`else
  localparam logic TMO_EXP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] err;
  int checks = 0, failures = 0;
  int m_ptr = 0, m_idle = 0;
  int m_q[$];
  logic [1:0] m_err = '0;
  int n_acc [N];
  int n_rsp [N];
  int obs_win, prev, alt_bad;
  always #5 clk = ~clk;
  bp_io_cmd_arbiter_if #(.num_req_p(N), .msg_width_p(W)) io ();
  bp_io_cmd_arbiter #(.num_req_p(N), .msg_width_p(W), .max_outstanding_p(MO), .timeout_p(TO)) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .io(io),
    .err_o(err)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    for (int i = 0; i < N; i++) begin
      n_acc[i] = 0;
      n_rsp[i] = 0;
    end
  endtask
  // one clock: check outputs against the model, then advance the model at the edge
  task automatic cyc();
    logic [N-1:0] ey, erv;
    int win, head;
    bit found, full, ne, rr, acc, deq, unexp;
    #2;
    full = (m_q.size() == MO);
    ne = (m_q.size() != 0);
    head = ne ? m_q[0] : 0;
    found = 1'b0;
    win = 0;
    for (int k = 0; k < N; k++)
      if (!found && io.req_cmd_v_i[(m_ptr + k) % N]) begin
        found = 1'b1;
        win = (m_ptr + k) % N;
      end
    acc = found && !full && io.cmd_yumi_i;
    ey = acc ? (N'(1) << win) : '0;
    erv = (io.resp_v_i && ne) ? (N'(1) << head) : '0;
    rr = ne && io.req_resp_ready_i[head];
    deq = io.resp_v_i && rr;
    unexp = io.resp_v_i && !ne;
    chk("cmd_v", io.cmd_v_o, found && !full);
    if (found && !full) chk("cmd_data", io.cmd_o, io.req_cmd_i[win]);
    chk("cmd_yumi", io.req_cmd_yumi_o, ey);
    chk("resp_v", io.req_resp_v_o, erv);
    chk("resp_ready", io.resp_ready_o, rr);
    chk("resp_data", io.req_resp_o, io.resp_i);
    chk("err", err, m_err);
    obs_win = -1;
    for (int i = 0; i < N; i++) begin
      n_acc[i] += int'(io.req_cmd_yumi_o[i]);
      n_rsp[i] += int'(io.req_resp_v_o[i] & io.req_resp_ready_i[i]);
      if (io.req_cmd_yumi_o[i]) obs_win = i;
    end
    @(posedge clk);
`ifdef BP_IO_CMD_ARB_TIMEOUT_EN
    if (m_idle == TO) m_err[1] = 1'b1;
    m_idle = (deq || !ne) ? 0 : (m_idle == TO ? TO : m_idle + 1);
`endif
    if (unexp) m_err[0] = 1'b1;
    if (deq) void'(m_q.pop_front());
    if (acc) begin
      m_q.push_back(win);
      m_ptr = (win + 1) % N;
    end
    #1;
  endtask
  task automatic drain();
    io.req_cmd_v_i = '0;
    io.cmd_yumi_i = 1'b0;
    io.req_resp_ready_i = '1;
    for (int c = 0; c < 20 && m_q.size() != 0; c++) begin
      io.resp_v_i = 1'b1;
      io.resp_i = W'($urandom);
      cyc();
    end
    io.resp_v_i = 1'b0;
  endtask
  task automatic do_reset();
    io.req_cmd_v_i = '0;
    io.cmd_yumi_i = 1'b0;
    io.resp_v_i = 1'b0;
    #2 rst_n = 1'b0;
    m_q.delete();
    m_ptr = 0;
    m_idle = 0;
    m_err = '0;
    #1;
    chk("rst_err", err, 2'b00);
    chk("rst_resp_ready", io.resp_ready_o, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
  endtask
  task automatic rand_cyc();
    io.req_cmd_v_i = N'($urandom);
    for (int i = 0; i < N; i++) io.req_cmd_i[i] = W'($urandom);
    io.cmd_yumi_i = 1'($urandom);
    io.req_resp_ready_i = N'($urandom);
    io.resp_v_i = (m_q.size() != 0) && ($urandom_range(0, 1) == 1);
    io.resp_i = W'($urandom);
    cyc();
  endtask
  initial begin
    io.req_cmd_i = '0;
    io.req_cmd_v_i = '0;
    io.req_resp_ready_i = '1;
    io.cmd_yumi_i = 1'b0;
    io.resp_i = '0;
    io.resp_v_i = 1'b0;
    clr();
    #12;
    chk("reset_cmd_v", io.cmd_v_o, 1'b0);
    chk("reset_yumi", io.req_cmd_yumi_o, '0);
    chk("reset_resp_v", io.req_resp_v_o, '0);
    chk("reset_resp_ready", io.resp_ready_o, 1'b0);
    chk("reset_err", err, 2'b00);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      io.req_cmd_v_i = 2'b01;
      io.req_cmd_i[0] = W'($urandom);
      io.cmd_yumi_i = 1'b1;
      io.resp_v_i = 1'b0;
      cyc();
      io.req_cmd_v_i = '0;
      io.cmd_yumi_i = 1'b0;
      io.resp_v_i = 1'b1;
      io.resp_i = W'($urandom);
      cyc();
    end
    io.resp_v_i = 1'b0;
    chk("t1_yumi0", n_acc[0], 3);
    chk("t1_yumi1", n_acc[1], 0);
    chk("t1_resp0", n_rsp[0], 3);
    chk("t1_resp1", n_rsp[1], 0);
    chk("t1_err", err, 2'b00);
    clr();
    prev = -1;
    alt_bad = 0;
    io.req_cmd_v_i = '1;
    io.cmd_yumi_i = 1'b1;
    for (int c = 0; c < 40 && (n_acc[0] + n_acc[1]) < 8; c++) begin
      io.req_cmd_i[0] = W'($urandom);
      io.req_cmd_i[1] = W'($urandom);
      io.resp_v_i = (m_q.size() != 0);
      io.resp_i = W'($urandom);
      cyc();
      if (obs_win >= 0) begin
        if (obs_win == prev) alt_bad++;
        prev = obs_win;
      end
    end
    chk("t2_accepts", n_acc[0] + n_acc[1], 8);
    chk("t2_alternate", alt_bad, 0);
    drain();
    chk("t2_resp0", n_rsp[0], 4);
    chk("t2_resp1", n_rsp[1], 4);
    clr();
    io.req_cmd_v_i = '1;
    io.cmd_yumi_i = 1'b1;
    io.resp_v_i = 1'b0;
    repeat (8) cyc();
    chk("t3_accepts", n_acc[0] + n_acc[1], 4);
    chk("t3_full_cmd_v", io.cmd_v_o, 1'b0);
    io.resp_v_i = 1'b1;
    cyc();
    chk("t3_no_bypass", n_acc[0] + n_acc[1], 4);
    io.resp_v_i = 1'b0;
    cyc();
    chk("t3_refill", n_acc[0] + n_acc[1], 5);
    drain();
    clr();
    io.req_cmd_v_i = 2'b01;
    io.cmd_yumi_i = 1'b1;
    cyc();
    io.req_cmd_v_i = 2'b10;
    io.req_resp_ready_i = 2'b10;
    io.resp_v_i = 1'b1;
    io.resp_i = W'($urandom);
    repeat (10) cyc();
    chk("t5_pending", n_rsp[0] + n_rsp[1], 0);
    chk("t5_other_issue", n_acc[1], 3);
    chk("t5_ready_low", io.resp_ready_o, 1'b0);
    io.req_cmd_v_i = '0;
    io.cmd_yumi_i = 1'b0;
    io.req_resp_ready_i = '1;
    cyc();
    chk("t5_head_done", n_rsp[0], 1);
    drain();
    chk("t5_order", n_rsp[1], 3);
    repeat (300) rand_cyc();
    drain();
    io.resp_v_i = 1'b1;
    cyc();
    io.resp_v_i = 1'b0;
    chk("t4_unexp", err, 2'b01);
    repeat (10) rand_cyc();
    drain();
    chk("t4_sticky", err, 2'b01);
    do_reset();
    io.req_cmd_v_i = 2'b11;
    io.cmd_yumi_i = 1'b1;
    repeat (2) cyc();
    do_reset();
    io.resp_v_i = 1'b1;
    cyc();
    io.resp_v_i = 1'b0;
    chk("mid_reset_unexp", err, 2'b01);
    do_reset();
    io.req_cmd_v_i = 2'b01;
    io.cmd_yumi_i = 1'b1;
    cyc();
    io.req_cmd_v_i = '0;
    io.cmd_yumi_i = 1'b0;
    repeat (20) cyc();
    chk("timeout_bit", err[1], TMO_EXP);
    chk("timeout_unexp", err[0], 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bp_io_cmd_arbiter.md
# bp_io_cmd_arbiter

Shares the processor's single inbound I/O command channel (io_cmd_i / io_resp_o) among several testbench or host-side requesters, such as the NBF loader and a debug/config master. It grants commands round-robin and records the requester of every accepted command in an in-order tag queue. It routes each returning response to the requester whose command produced it. It sits between the requesters and the wrapper's io_cmd_i/io_cmd_yumi_o and io_resp_o/io_resp_v_o/io_resp_ready_i ports.

## Interface
- num_req_p, 2, number of requesters (≥2)
- msg_width_p, none, width of one packed bp_cce_mem_msg_s
- max_outstanding_p, 4, tag-queue depth, i.e. accepted commands awaiting response (≥2)
- timeout_p, 4096, cycles without a response before timeout error (timeout build only)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- req_cmd_i  in  num_req_p×msg_width_p  per-requester command
- req_cmd_v_i  in  num_req_p  per-requester command valid
- req_cmd_yumi_o  out  num_req_p  command consumed this cycle (one-hot or zero)
- req_resp_o  out  msg_width_p  response data, broadcast
- req_resp_v_o  out  num_req_p  response valid, one-hot or zero
- req_resp_ready_i  in  num_req_p  per-requester response ready
- cmd_o  out  msg_width_p  command to processor
- cmd_v_o  out  1  command valid
- cmd_yumi_i  in  1  processor consumed command
- resp_i  in  msg_width_p  response from processor
- resp_v_i  in  1  response valid
- resp_ready_o  out  1  arbiter can take response
- err_o  out  2  sticky error: bit0 unexpected response, bit1 timeout

## Operation
- Reset values:
  - round-robin pointer = 0
  - tag queue empty
  - err_o = 0
  - cmd_v_o = 0, req_cmd_yumi_o = 0, req_resp_v_o = 0, resp_ready_o = 0
- Grant:
  - Eligible requester: req_cmd_v_i set and tag queue not full.
  - Winner is the first eligible requester at or after the pointer, modulo num_req_p.
  - cmd_o/cmd_v_o present the winner's command.
  - On cmd_yumi_i: req_cmd_yumi_o[winner]=1, winner id is enqueued, and the pointer becomes winner+1 (wraps to 0).
  - With no cmd_yumi_i the pointer does not move. The winner may change next cycle if another requester becomes valid; no lock.
- Full queue:
  - cmd_v_o=0 and no yumi.
  - A dequeue in the same cycle does not free the slot for that cycle (no bypass).
- Response:
  - head = oldest queued id.
  - req_resp_v_o[head] = resp_v_i & queue non-empty.
  - resp_ready_o = queue non-empty & req_resp_ready_i[head].
  - The queue dequeues on resp_v_i & resp_ready_o.
- Unexpected response (resp_v_i with queue empty):
  - Set err_o[0]; resp_ready_o stays 0 and the response is not consumed.
  - A command enqueued in the same cycle does not cover it (no bypass).
- Errors are cleared only by reset. Arbitration continues after an error.

## Timing
- Command path is combinational, zero added latency. cmd_v_o does not depend on cmd_yumi_i.
- Response routing is combinational. resp_ready_o depends on req_resp_ready_i; there is no path from resp_v_i to resp_ready_o.
- Tag queue and pointer update on posedge clk_i.
- An id enqueued in cycle N is usable as head from cycle N+1.
- Asynchronous reset mid-transaction drops all queued tags immediately. Responses still in flight afterwards are flagged as unexpected.

## Configuration
- BP_IO_CMD_ARB_TIMEOUT_EN defined:
  - Idle counter clears on any dequeue or when the queue is empty, and increments otherwise.
  - When it reaches timeout_p it sets err_o[1] and saturates.
- Not defined: no counter; err_o[1] is tied 0 and timeout_p is ignored.

## Structure
- err_o bit positions (e_io_arb_err_unexp=0, e_io_arb_err_timeout=1) belong in bp_me_pkg.
- Requester-id width is local: `$clog2(num_req_p)`.
- Tag queue is one sub-module, bsg_fifo_1r1w_small: width = id width, els = max_outstanding_p, ready_then_valid.
- Round-robin logic is inline.

## Test plan
- Single requester 0 sends 3 commands, processor yumis each immediately and responds in order → 3 yumis on requester 0, each response seen only on req_resp_v_o[0], err_o=0.
- Both requesters valid continuously, 8 commands accepted → grants alternate 0,1,0,1,… and responses route alternately.
- Processor withholds responses, both requesters valid → exactly 4 commands accepted, then cmd_v_o=0 until one response dequeues, then 1 more accepted the following cycle.
- resp_v_i=1 with queue empty → err_o=2'b01 next cycle, resp_ready_o=0; stays set across later traffic until reset_n_i low.
- Head requester holds req_resp_ready_i=0 for 10 cycles → resp_ready_o=0, the response stays pending, and the other requester's commands still issue. After ready rises the response completes with no ordering violation.
- With BP_IO_CMD_ARB_TIMEOUT_EN and timeout_p=16: one command accepted, no response → err_o[1]=1 after 16 cycles. Without the macro, err_o[1] stays 0.
